// File: rtl/pc_update_if.sv
// Fetch-side bundle between the CPU control logic and the program-counter block.
// Master drives stall/redirect decisions; slave returns the fetch address and status.
interface pc_update_if #(
    parameter int CNT_W = 16
);
    logic             busywait;
    logic             beq_taken;
    logic             bne_taken;
    logic             jump;
    logic [7:0]       offset;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             stalled;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output busywait, beq_taken, bne_taken, jump, offset,
        input  pc, pc_plus4, stalled, instr_count
    );

    modport slave (
        input  busywait, beq_taken, bne_taken, jump, offset,
        output pc, pc_plus4, stalled, instr_count
    );
endinterface

// File: rtl/pc_update.sv
// Program counter with next-PC select (sequential / branch / jump) and stall-safe redirect capture.
// Latency: decisions sampled at edge N appear on pc after edge N; pc_plus4 is combinational.
// Backpressure: busywait freezes pc; a redirect seen during the stall is held and applied on release.
module pc_update #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    pc_update_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN           = 2'd0,
        HOLD          = 2'd1,
        HOLD_REDIRECT = 2'd2
    } state_t;

    state_t           state;
    logic [31:0]      pc;
    logic [31:0]      pend;
    logic             stalled;
    logic [CNT_W-1:0] cnt;

    logic [31:0]      pc_plus4;
    logic [31:0]      target;
    logic [31:0]      next_seq;
    logic             redirect;

    assign pc_plus4 = pc + 32'd4;
    // offset counts instruction words, so scale by 4 before adding
    assign target   = pc_plus4 + {{22{bus.offset[7]}}, bus.offset, 2'b00};
    assign redirect = bus.jump | bus.beq_taken | bus.bne_taken;
    assign next_seq = redirect ? target : pc_plus4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            pc      <= RESET_PC;
            pend    <= 32'd0;
            stalled <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!bus.busywait) begin
                        pc  <= next_seq;
                        cnt <= cnt + 1'b1;
                    end else if (redirect) begin
                        pend    <= target;
                        state   <= HOLD_REDIRECT;
                        stalled <= 1'b1;
                    end else begin
                        state   <= HOLD;
                        stalled <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.busywait) begin
                        if (redirect) begin
                            pend  <= target;
                            state <= HOLD_REDIRECT;
                        end
                    end else begin
                        pc      <= next_seq;
                        cnt     <= cnt + 1'b1;
                        state   <= RUN;
                        stalled <= 1'b0;
                    end
                end
                HOLD_REDIRECT: begin
                    // first captured target wins; live redirect inputs are ignored here
                    if (!bus.busywait) begin
                        pc      <= pend;
                        cnt     <= cnt + 1'b1;
                        state   <= RUN;
                        stalled <= 1'b0;
                    end
                end
                default: begin
                    state   <= RUN;
                    stalled <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = pc;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.stalled     = stalled;
    assign bus.instr_count = cnt;

endmodule
